// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared branch funct3/flag constants and condition helpers
package core_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    localparam logic [1:0] BHT_RESET = 2'b01;

    // Flags come from rs1-rs2; unsigned "less than" is a borrow, i.e. carry clear.
    function automatic logic br_cond(input logic [2:0] f3, input logic [3:0] fl);
        logic r;
        r = 1'b0;
        case (f3)
            BR_BEQ:  r = fl[FLAG_Z];
            BR_BNE:  r = ~fl[FLAG_Z];
            BR_BLT:  r = fl[FLAG_N] ^ fl[FLAG_V];
            BR_BGE:  r = ~(fl[FLAG_N] ^ fl[FLAG_V]);
            BR_BLTU: r = ~fl[FLAG_C];
            BR_BGEU: r = fl[FLAG_C];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic br_illegal(input logic [2:0] f3);
        return f3[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - EX/fetch side bus of the branch resolve unit
interface branch_resolve_unit_if #(
    parameter int PC_W = 32
);
    logic            ex_valid;
    logic            ex_branch;
    logic            ex_jump;
    logic [2:0]      ex_funct3;
    logic [3:0]      ex_flags;
    logic [PC_W-1:0] ex_pc;
    logic [PC_W-1:0] ex_target;
    logic [PC_W-1:0] ex_pred_pc;
    logic            stall;
    logic [PC_W-1:0] if_pc;
    logic            if_pred_taken;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            illegal_br;
    logic [31:0]     branch_count;
    logic [31:0]     mispredict_count;

    modport master (
        output ex_valid, ex_branch, ex_jump, ex_funct3, ex_flags, ex_pc, ex_target,
               ex_pred_pc, stall, if_pc,
        input  if_pred_taken, redirect_valid, redirect_pc, illegal_br,
               branch_count, mispredict_count
    );

    modport slave (
        input  ex_valid, ex_branch, ex_jump, ex_funct3, ex_flags, ex_pc, ex_target,
               ex_pred_pc, stall, if_pc,
        output if_pred_taken, redirect_valid, redirect_pc, illegal_br,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/bht_2bit.sv
// rtl/bht_2bit.sv - 2-bit saturating counter table, async read, one write port
module bht_2bit
    import core_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    logic [1:0] cnt [ENTRIES];
    logic [1:0] cur;
    logic [1:0] nxt;

    // Read sees the stored value, so a same-cycle update is visible only next cycle.
    assign rd_cnt = cnt[rd_idx];
    assign cur    = cnt[wr_idx];

    always_comb begin
        nxt = cur;
        if (wr_taken) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) cnt[i] <= BHT_RESET;
        end else if (wr_en) begin
            cnt[wr_idx] <= nxt;
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX branch resolution, redirect/flush, BHT owner
module branch_resolve_unit
    import core_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_W       = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    branch_resolve_unit_if.slave bus
);
    logic            resolve;
    logic            cond;
    logic            illegal;
    logic            taken;
    logic [PC_W-1:0] correct_pc;
    logic            mispredict;
    logic            bht_wr;
    logic [1:0]      rd_cnt;
    logic            unused_if_pc_bits;

    // The cycle after a redirect carries a wrong-path instruction; it must not resolve.
    assign resolve    = bus.ex_valid & (bus.ex_branch | bus.ex_jump) & ~bus.stall
                        & ~bus.redirect_valid;
    assign cond       = br_cond(bus.ex_funct3, bus.ex_flags);
    assign illegal    = br_illegal(bus.ex_funct3);
    assign taken      = bus.ex_jump | (bus.ex_branch & cond);
    assign correct_pc = taken ? bus.ex_target : bus.ex_pc + PC_W'(4);
    assign mispredict = resolve & (correct_pc != bus.ex_pred_pc);
    assign bht_wr     = resolve & bus.ex_branch & ~illegal;

    assign bus.if_pred_taken = rd_cnt[1];
    assign unused_if_pc_bits = ^{bus.if_pc[PC_W-1:IDX_W+2], bus.if_pc[1:0],
                                 bus.ex_pc[1:0]};

    bht_2bit #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_idx   (bus.if_pc[IDX_W+1:2]),
        .rd_cnt   (rd_cnt),
        .wr_en    (bht_wr),
        .wr_idx   (bus.ex_pc[IDX_W+1:2]),
        .wr_taken (taken)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.redirect_valid   <= 1'b0;
            bus.redirect_pc      <= '0;
            bus.illegal_br       <= 1'b0;
            bus.branch_count     <= '0;
            bus.mispredict_count <= '0;
        end else begin
            bus.redirect_valid <= mispredict;
            bus.illegal_br     <= resolve & bus.ex_branch & illegal;
            if (mispredict) begin
                bus.redirect_pc      <= correct_pc;
                bus.mispredict_count <= bus.mispredict_count + 32'd1;
            end
            if (resolve) bus.branch_count <= bus.branch_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
    import core_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    branch_resolve_unit_if #(.PC_W(32)) bus ();

    branch_resolve_unit #(.PC_W(32), .BHT_ENTRIES(64), .IDX_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic br, input logic jp, input logic [2:0] f3,
                         input logic [3:0] fl, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] pred);
        bus.ex_valid   = v;
        bus.ex_branch  = br;
        bus.ex_jump    = jp;
        bus.ex_funct3  = f3;
        bus.ex_flags   = fl;
        bus.ex_pc      = pc;
        bus.ex_target  = tgt;
        bus.ex_pred_pc = pred;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag, input int br, input int mis);
        check({tag, "_branch_count"}, bus.branch_count, br);
        check({tag, "_mispredict_count"}, bus.mispredict_count, mis);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.stall = 1'b0;
        bus.if_pc = 32'h100;
        idle();

        // 1: reset state
        #12;
        check("rst_redirect_valid", bus.redirect_valid, 0);
        check("rst_redirect_pc", bus.redirect_pc, 0);
        check_counts("rst", 0, 0);
        check("rst_pred_taken", bus.if_pred_taken, 0);
        check("rst_illegal", bus.illegal_br, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // 2: beq taken, predicted fall-through
        drive(1'b1, 1'b1, 1'b0, BR_BEQ, 4'b0001, 32'h100, 32'h140, 32'h104);
        step();
        idle();
        check("beq_redirect_valid", bus.redirect_valid, 1);
        check("beq_redirect_pc", bus.redirect_pc, 32'h140);
        check_counts("beq", 1, 1);
        check("beq_bht", dut.u_bht.cnt[0], 2);
        check("beq_pred_taken", bus.if_pred_taken, 1);
        step();
        check("beq_pulse_end", bus.redirect_valid, 0);

        // 3: condition decode at pc 0x340 (bht index 0x10)
        drive(1'b1, 1'b1, 1'b0, BR_BLT, 4'b1000, 32'h340, 32'h380, 32'h380);
        step();
        check("blt_taken_noredir", bus.redirect_valid, 0);
        drive(1'b1, 1'b1, 1'b0, BR_BLT, 4'b1010, 32'h340, 32'h380, 32'h344);
        step();
        check("blt_nt_noredir", bus.redirect_valid, 0);
        check("blt_nt_count", bus.branch_count, 3);
        drive(1'b1, 1'b1, 1'b0, BR_BLTU, 4'b0000, 32'h340, 32'h380, 32'h380);
        step();
        check("bltu_noredir", bus.redirect_valid, 0);
        drive(1'b1, 1'b1, 1'b0, BR_BGEU, 4'b0100, 32'h340, 32'h380, 32'h380);
        step();
        check("bgeu_noredir", bus.redirect_valid, 0);
        drive(1'b1, 1'b1, 1'b0, 3'b010, 4'b0000, 32'h340, 32'h380, 32'h344);
        step();
        check("illegal_set", bus.illegal_br, 1);
        check("illegal_noredir", bus.redirect_valid, 0);
        drive(1'b1, 1'b1, 1'b0, BR_BGE, 4'b1000, 32'h340, 32'h380, 32'h380);
        step();
        idle();
        check("illegal_clear", bus.illegal_br, 0);
        check("bge_redirect_valid", bus.redirect_valid, 1);
        check("bge_redirect_pc", bus.redirect_pc, 32'h344);
        check_counts("decode", 7, 2);
        check("decode_bht", dut.u_bht.cnt[16], 2);
        step();

        // 4: saturation at pc 0x200 (shares index 0 with 0x100)
        bus.if_pc = 32'h200;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0, BR_BEQ, 4'b0001, 32'h200, 32'h240, 32'h240);
            check("sat_pred_before", bus.if_pred_taken, 1);
            step();
            check("sat_noredir", bus.redirect_valid, 0);
        end
        check("sat_bht_11", dut.u_bht.cnt[0], 3);
        drive(1'b1, 1'b1, 1'b0, BR_BEQ, 4'b0000, 32'h200, 32'h240, 32'h204);
        step();
        check("sat_bht_10", dut.u_bht.cnt[0], 2);
        check("sat_pred_after", bus.if_pred_taken, 1);
        check("sat_count", bus.branch_count, 12);

        // same-cycle lookup: counter 10 -> 01, lookup sees old MSB
        bus.if_pc = 32'h340;
        drive(1'b1, 1'b1, 1'b0, BR_BEQ, 4'b0000, 32'h340, 32'h380, 32'h344);
        #1;
        check("samecyc_old", bus.if_pred_taken, 1);
        step();
        idle();
        check("samecyc_new", bus.if_pred_taken, 0);

        // 5: mispredict then wrong-path branch in the redirect cycle
        drive(1'b1, 1'b1, 1'b0, BR_BEQ, 4'b0000, 32'h400, 32'h440, 32'h440);
        step();
        check("wp_redirect_pc", bus.redirect_pc, 32'h404);
        drive(1'b1, 1'b1, 1'b0, BR_BNE, 4'b0000, 32'h404, 32'h500, 32'h408);
        step();
        check("wp_redirect_clear", bus.redirect_valid, 0);
        check_counts("wp", 14, 3);
        check("wp_bht_untouched", dut.u_bht.cnt[1], 1);
        check("wp_bht0", dut.u_bht.cnt[0], 1);
        bus.stall = 1'b1;
        step();
        check("stall_noredir", bus.redirect_valid, 0);
        check_counts("stall", 14, 3);
        check("stall_bht", dut.u_bht.cnt[1], 1);
        bus.stall = 1'b0;
        drive(1'b1, 1'b0, 1'b1, BR_BEQ, 4'b0000, 32'h340, 32'h800, 32'h344);
        step();
        idle();
        check("jal_redirect_valid", bus.redirect_valid, 1);
        check("jal_redirect_pc", bus.redirect_pc, 32'h800);
        check_counts("jal", 15, 4);
        check("jal_no_bht", dut.u_bht.cnt[16], 1);
        step();

        // 6: reset during redirect pulse
        drive(1'b1, 1'b1, 1'b0, BR_BEQ, 4'b0001, 32'h100, 32'h140, 32'h104);
        step();
        idle();
        check("pre_rst_redirect", bus.redirect_valid, 1);
        check("pre_rst_bht", dut.u_bht.cnt[0], 2);
        reset_n = 1'b0;
        #1;
        check("mid_rst_redirect", bus.redirect_valid, 0);
        check("mid_rst_bht", dut.u_bht.cnt[0], 1);
        check_counts("mid_rst", 0, 0);
        step();
        reset_n = 1'b1;
        step();
        step();
        check("post_rst_redirect", bus.redirect_valid, 0);
        check("post_rst_pc", bus.redirect_pc, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
